// File: rtl/slib_mv_filter_mc_if.sv
// Bus bundle for slib_mv_filter_mc.
// The master side (the bench or parent logic) drives the sample strobe,
// the per-channel clears, the mode, the thresholds and the raw inputs.
// The slave side (the filter) returns the filtered levels and the
// one-cycle edge pulses.
//   sample  shared sample strobe
//   clear   per-channel synchronous clear
//   mode    0 = sticky set, 1 = hysteresis integrator
//   thr_hi  set threshold
//   thr_lo  release threshold (integrator mode only)
//   d       raw channel inputs, already synchronised
//   q       filtered channel outputs
//   rise    one-cycle pulse when q goes 0->1
//   fall    one-cycle pulse when q goes 1->0
interface slib_mv_filter_mc_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4
);
    logic              sample;
    logic [NUM_CH-1:0] clear;
    logic              mode;
    logic [WIDTH-1:0]  thr_hi;
    logic [WIDTH-1:0]  thr_lo;
    logic [NUM_CH-1:0] d;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    modport master (
        output sample, clear, mode, thr_hi, thr_lo, d,
        input  q, rise, fall
    );

    modport slave (
        input  sample, clear, mode, thr_hi, thr_lo, d,
        output q, rise, fall
    );
endinterface

// File: rtl/slib_mv_filter_mc.sv
// Multi-channel glitch filter for slow or noisy lines (UART RXD, modem
// status lines). Every channel owns a saturating counter. In sticky mode
// the counter only counts up while the input is high and the output latches
// once the set threshold is reached. In integrator mode the counter follows
// the input up and down, and the output switches with hysteresis between
// the two thresholds. Edge pulses are registered alongside the output.
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset, overrides everything
//   bus  slave side of slib_mv_filter_mc_if (controls, inputs, outputs)
module slib_mv_filter_mc #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    slib_mv_filter_mc_if.slave   bus
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_INIT = (RST_VAL != 0) ? CNT_MAX : '0;
    localparam logic             Q_INIT   = (RST_VAL != 0);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - WIDTH'(1);
    endfunction

    logic [WIDTH-1:0]  cnt_p1  [NUM_CH];
    logic [WIDTH-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] q_p1;
    logic [NUM_CH-1:0] q_nxt;
    logic [NUM_CH-1:0] rise_p1;
    logic [NUM_CH-1:0] fall_p1;

    // Next count and next level, evaluated as if this edge were a sample edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt_p1[i];
            q_nxt[i]   = q_p1[i];
            if (!bus.mode) begin
                // Sticky: once set, the counter and output freeze until cleared.
                if (!q_p1[i]) begin
                    if (bus.d[i]) begin
                        cnt_nxt[i] = sat_inc(cnt_p1[i]);
                    end
                    q_nxt[i] = (cnt_nxt[i] >= bus.thr_hi);
                end
            end else begin
                cnt_nxt[i] = bus.d[i] ? sat_inc(cnt_p1[i]) : sat_dec(cnt_p1[i]);
                // Set is tested first so overlapping thresholds resolve to set.
                if (cnt_nxt[i] >= bus.thr_hi) begin
                    q_nxt[i] = 1'b1;
                end else if (cnt_nxt[i] <= bus.thr_lo) begin
                    q_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Stage p1: counters, filtered levels and edge pulses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || bus.clear[i]) begin
                cnt_p1[i]  <= CNT_INIT;
                q_p1[i]    <= Q_INIT;
                rise_p1[i] <= 1'b0;
                fall_p1[i] <= 1'b0;
            end else if (bus.sample) begin
                cnt_p1[i]  <= cnt_nxt[i];
                q_p1[i]    <= q_nxt[i];
                rise_p1[i] <= q_nxt[i] & ~q_p1[i];
                fall_p1[i] <= ~q_nxt[i] & q_p1[i];
            end else begin
                rise_p1[i] <= 1'b0;
                fall_p1[i] <= 1'b0;
            end
        end
    end

    assign bus.q    = q_p1;
    assign bus.rise = rise_p1;
    assign bus.fall = fall_p1;

endmodule

// File: tb/tb_slib_mv_filter_mc.sv
module tb_slib_mv_filter_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    slib_mv_filter_mc_if #(.NUM_CH(4), .WIDTH(4)) b0 ();
    slib_mv_filter_mc_if #(.NUM_CH(4), .WIDTH(4)) b1 ();

    slib_mv_filter_mc #(.NUM_CH(4), .WIDTH(4), .RST_VAL(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    slib_mv_filter_mc #(.NUM_CH(4), .WIDTH(4), .RST_VAL(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
        string      name;
    } exp_t;

    exp_t exp0 [$];
    exp_t exp1 [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Monitors: one expectation per clock edge, checked half a cycle later.
    always @(negedge clk) begin
        if (exp0.size() > 0) begin
            exp_t e;
            e = exp0.pop_front();
            n_cmp++;
            if (b0.q !== e.q || b0.rise !== e.r || b0.fall !== e.f) begin
                n_bad++;
                $display("FAIL dut0 %s: got q=%b rise=%b fall=%b, want q=%b rise=%b fall=%b",
                         e.name, b0.q, b0.rise, b0.fall, e.q, e.r, e.f);
            end
        end
    end

    always @(negedge clk) begin
        if (exp1.size() > 0) begin
            exp_t e;
            e = exp1.pop_front();
            n_cmp++;
            if (b1.q !== e.q || b1.rise !== e.r || b1.fall !== e.f) begin
                n_bad++;
                $display("FAIL dut1 %s: got q=%b rise=%b fall=%b, want q=%b rise=%b fall=%b",
                         e.name, b1.q, b1.rise, b1.fall, e.q, e.r, e.f);
            end
        end
    end

    task automatic set_cfg(input int sel, input logic m, input logic [3:0] hi,
                           input logic [3:0] lo);
        if (sel == 0) begin
            b0.mode = m; b0.thr_hi = hi; b0.thr_lo = lo;
        end else begin
            b1.mode = m; b1.thr_hi = hi; b1.thr_lo = lo;
        end
    endtask

    // Drive one cycle on the selected DUT (the other one idles) and queue
    // the outputs expected after that edge.
    task automatic tick(input int sel, input logic s, input logic [3:0] clr,
                        input logic [3:0] dv, input logic [3:0] eq,
                        input logic [3:0] er, input logic [3:0] ef,
                        input string nm);
        exp_t e;
        if (sel == 0) begin
            b0.sample = s; b0.clear = clr; b0.d = dv;
            b1.sample = 1'b0; b1.clear = '0;
        end else begin
            b1.sample = s; b1.clear = clr; b1.d = dv;
            b0.sample = 1'b0; b0.clear = '0;
        end
        @(posedge clk);
        #1;
        e.q = eq; e.r = er; e.f = ef; e.name = nm;
        if (sel == 0) exp0.push_back(e);
        else          exp1.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.sample = 0; b0.clear = '0; b0.mode = 0; b0.thr_hi = '0; b0.thr_lo = '0; b0.d = '0;
        b1.sample = 0; b1.clear = '0; b1.mode = 0; b1.thr_hi = '0; b1.thr_lo = '0; b1.d = '0;
        #1;

        // Reset state of both variants
        rst = 1'b1;
        tick(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, "reset_idle_low");
        tick(1, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "reset_idle_high");
        rst = 1'b0;

        // Sticky mode: rise on the 10th sample, then latched
        set_cfg(0, 0, 4'd10, 4'd0);
        for (int k = 1; k <= 10; k++)
            tick(0, 1, 4'h0, 4'b0001, (k >= 10) ? 4'b0001 : 4'b0000,
                 (k == 10) ? 4'b0001 : 4'b0000, 4'h0, "sticky_count");
        for (int k = 0; k < 3; k++)
            tick(0, 1, 4'h0, 4'b0000, 4'b0001, 4'h0, 4'h0, "sticky_hold");
        tick(0, 0, 4'h0, 4'b0001, 4'b0001, 4'h0, 4'h0, "sticky_nosample");
        tick(0, 0, 4'hF, 4'b0000, 4'h0, 4'h0, 4'h0, "clear_no_fall");

        // Zero set threshold with overlapping release threshold: set wins
        set_cfg(0, 1, 4'd0, 4'd0);
        tick(0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, "thr_hi_zero");
        tick(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "clear_after_thr0");

        // Hysteresis: set on 12th high sample, fall on 12th low sample
        set_cfg(0, 1, 4'd12, 4'd3);
        for (int k = 1; k <= 15; k++)
            tick(0, 1, 4'h0, 4'b0001, (k >= 12) ? 4'b0001 : 4'b0000,
                 (k == 12) ? 4'b0001 : 4'b0000, 4'h0, "hyst_up");
        for (int k = 1; k <= 12; k++)
            tick(0, 1, 4'h0, 4'b0000, (k < 12) ? 4'b0001 : 4'b0000, 4'h0,
                 (k == 12) ? 4'b0001 : 4'b0000, "hyst_down");

        // Glitch rejection: alternating input never reaches the threshold
        tick(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "clear_before_glitch");
        set_cfg(0, 1, 4'd8, 4'd2);
        for (int k = 0; k < 40; k++)
            tick(0, 1, 4'h0, (k % 2 == 0) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'h0, "glitch_reject");

        // Saturation at both ends, sample gating, mode changes
        tick(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "clear_before_sat");
        set_cfg(0, 1, 4'd15, 4'd13);
        for (int k = 1; k <= 40; k++)
            tick(0, 1, 4'h0, 4'b0001, (k >= 15) ? 4'b0001 : 4'b0000,
                 (k == 15) ? 4'b0001 : 4'b0000, 4'h0, "sat_up");
        tick(0, 1, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, "sat_first_dec");
        tick(0, 1, 4'h0, 4'h0, 4'b0000, 4'h0, 4'b0001, "sat_second_dec");
        for (int k = 0; k < 20; k++)
            tick(0, 0, 4'h0, (k % 2 == 0) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'h0, "nosample_hold");
        tick(0, 1, 4'h0, 4'hF, 4'b0000, 4'h0, 4'h0, "after_nosample");
        tick(0, 1, 4'h0, 4'hF, 4'b0001, 4'b0001, 4'h0, "sat_reset");
        set_cfg(0, 0, 4'd15, 4'd13);
        tick(0, 1, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, "mode10_keep");
        set_cfg(0, 1, 4'd15, 4'd13);
        tick(0, 1, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, "mode01_resume");
        tick(0, 1, 4'h0, 4'h0, 4'b0000, 4'h0, 4'b0001, "mode01_fall");

        // Clear priority over sample, other channels untouched
        tick(0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, "clear_before_prio");
        set_cfg(0, 1, 4'd2, 4'd0);
        tick(0, 1, 4'h0, 4'b0011, 4'b0000, 4'h0, 4'h0, "prio_up1");
        tick(0, 1, 4'h0, 4'b0011, 4'b0011, 4'b0011, 4'h0, "prio_up2");
        tick(0, 1, 4'b0010, 4'b0011, 4'b0001, 4'h0, 4'h0, "clear_prio");
        tick(0, 1, 4'h0, 4'b0011, 4'b0001, 4'h0, 4'h0, "clear_cnt1");
        tick(0, 1, 4'h0, 4'b0011, 4'b0011, 4'b0010, 4'h0, "clear_cnt2");
        rst = 1'b1;
        tick(0, 1, 4'b0001, 4'b0011, 4'h0, 4'h0, 4'h0, "rst_over_clear");
        rst = 1'b0;

        // Idle-high variant: falls on the 12th low sample
        set_cfg(1, 1, 4'd15, 4'd3);
        for (int k = 1; k <= 12; k++)
            tick(1, 1, 4'h0, 4'h0, (k < 12) ? 4'hF : 4'h0, 4'h0,
                 (k == 12) ? 4'hF : 4'h0, "idle_high_fall");
        tick(1, 0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "clear_idle_high");

        repeat (3) @(posedge clk);
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", exp0.size(), exp1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
